sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single 16-bit board SRAM between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage MIPS pipeline. Each 32-bit access is split into two 16-bit SRAM beats under a state machine, and completed results are held per port. A global `freeze` stalls the whole pipeline until every active request of the current pipeline cycle has completed.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width in 16-bit halfwords.
- WAIT_CYCLES, 1, cycles each beat is held on the SRAM bus (≥1).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset: asynchronous, active-high.
- if_req  in  1  instruction read request (level, held while frozen).
- if_addr  in  32  instruction byte address.
- if_rdata  out  32  instruction word, valid while if_ready.
- if_ready  out  1  instruction request completed this pipeline cycle.
- mem_r_en  in  1  data load request.
- mem_w_en  in  1  data store request. Wins if asserted together with mem_r_en.
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data, valid while mem_ready.
- mem_ready  out  1  data request completed this pipeline cycle.
- freeze  out  1  stall to all pipeline registers and the PC.
- sram_addr  out  ADDR_W  halfword address.
- sram_dq_out  out  16  write data.
- sram_dq_in  in  16  read data.
- sram_dq_oe  out  1  drive dq (writes only).
- sram_we_n  out  1  write strobe, active-low.

## Operation
- **Address mapping.** sram_addr = {addr[ADDR_W:2], beat}. Beat 0 carries bits [15:0]; beat 1 carries bits [31:16]. addr[1:0] is ignored.
- **Pending conditions.**
  - if_pend = if_req & ~if_done.
  - mem_pend = (mem_r_en | mem_w_en) & ~mem_done.
- **Ready outputs.** if_ready = if_done and mem_ready = mem_done. Each done flag is set when its transaction finishes.
- **Freeze.** freeze = if_pend | mem_pend (combinational).
- **Done clearing.** On any clock edge where freeze = 0, both done flags clear, because the pipeline advances. A request therefore completes exactly once per pipeline cycle.
- **States.**
  - IDLE: grant on pending. Data port has priority over the instruction port. Latch the port, the address, the write data and rw. Go to LO.
  - LO: drive beat 0 for WAIT_CYCLES cycles, then go to HI. On a read, capture sram_dq_in into the low half on the last cycle.
  - HI: drive beat 1 for WAIT_CYCLES cycles, then go to DONE. On a read, capture the high half on the last cycle.
  - DONE: set the granted port's done flag, load its rdata register, go to IDLE.
- **Write beats.** sram_dq_oe = 1 and sram_we_n = 0 for all cycles of both beats. sram_dq_out = latched halfword.
- **Read beats.** sram_dq_oe = 0 and sram_we_n = 1.
- **Request withdrawn mid-transaction.** The transaction still runs to DONE and its done flag is set. If freeze is already low, the flag clears on the next edge.
- **if_rdata / mem_rdata** hold their last value until the next completion of the same port.
- **Reset** (any time, including mid-beat):
  - state = IDLE, done flags = 0, rdata = 0.
  - sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0.
  - With no requests pending, freeze = 0.

## Timing
- **Single request latency.** Request present at edge E (state IDLE) → LO from E+1 → HI from E+1+WAIT_CYCLES → DONE at E+1+2·WAIT_CYCLES → ready high from E+2+2·WAIT_CYCLES.
- **With WAIT_CYCLES = 1:** ready, and freeze low, 4 cycles after the request is first seen.
- **Both ports pending.** The second transaction starts in the IDLE cycle after the first one's DONE. Freeze stays high until both are done, i.e. 2·(2·WAIT_CYCLES+2) cycles.
- **Freeze is combinational** from the requests and done flags, with no extra register stage. Ready flags are registered.

## Configuration
- **SRAM_ARB_RR_EN defined:** round-robin grant. A one-bit last_grant register, reset to the instruction port, gives priority to the port not granted last when both are pending.
- **SRAM_ARB_RR_EN undefined:** fixed priority, data port always first. No last_grant register.

## Structure
- **Package mips_mem_pkg:**
  - state enum {IDLE, LO, HI, DONE}.
  - port id constants PORT_IF and PORT_MEM.
  - SRAM data width constant (16).
- **Sub-module sram_arb_grant:** combinational plus last_grant register. Inputs if_pend and mem_pend, output grant id. Holds the SRAM_ARB_RR_EN variant.

## Test plan
All scenarios use WAIT_CYCLES = 1 and a behavioural SRAM model.
- Reset mid-write (rst during LO of a store) → next cycle we_n = 1, dq_oe = 0, state IDLE, freeze = 0 with no requests.
- if_req, if_addr = 0x0000_0008, SRAM halfwords [4] = 0x5678, [5] = 0x1234:
  - sram_addr = 4 then 5.
  - if_rdata = 0x1234_5678 and if_ready high 4 cycles after the request.
  - freeze low that cycle.
- mem_w_en, mem_addr = 0x10, wdata = 0xDEAD_BEEF:
  - we_n low for 2 cycles.
  - sram[8] = 0xBEEF, sram[9] = 0xDEAD.
  - mem_ready after 4 cycles.
  - Readback via mem_r_en returns 0xDEAD_BEEF.
- if_req and mem_r_en together:
  - Data served first, then instruction.
  - freeze high for 8 cycles.
  - Each port done exactly once; no repeated SRAM access after freeze falls.
- With SRAM_ARB_RR_EN, two consecutive contended pipeline cycles → grant order MEM, IF then IF, MEM. Without the macro → MEM first both times.
- mem_r_en dropped during HI → DONE still reached, mem_done set, and cleared on the next edge (freeze low).

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the SRAM arbiter: FSM states, port ids and SRAM data width.
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} arbState_t;

  localparam logic PORT_IF  = 1'b0;
  localparam logic PORT_MEM = 1'b1;
  localparam int   SRAM_DW  = 16;
endpackage

// File: rtl/sram_arb_grant.sv
// Grant selection between fetch and memory ports.
// SRAM_ARB_RR_EN selects round-robin on contention; otherwise the data port always wins.
module sram_arb_grant
  import mips_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ifPend,
  input  logic memPend,
  input  logic update,
  output logic grant
);

`ifdef SRAM_ARB_RR_EN
  logic lastGrant;

  // Only contended grants move the pointer, so uncontended traffic leaves fairness intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               lastGrant <= PORT_IF;
    else if (update && ifPend && memPend)  lastGrant <= grant;
  end

  always_comb begin
    grant = memPend ? PORT_MEM : PORT_IF;
    if (ifPend && memPend) grant = ~lastGrant;
  end
`else
  wire unusedGrantIn = &{1'b0, clk, rst, update, ifPend};

  assign grant = memPend ? PORT_MEM : PORT_IF;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 16-bit SRAM between fetch and memory stages; each 32-bit access is two beats.
// Optional SRAM_ARB_RR_EN switches the grant to round-robin (see sram_arb_grant).
module sram_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [31:0]         if_addr,
  output logic [31:0]         if_rdata,
  output logic                if_ready,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  output logic [31:0]         mem_rdata,
  output logic                mem_ready,
  output logic                freeze,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]  sram_dq_out,
  input  logic [SRAM_DW-1:0]  sram_dq_in,
  output logic                sram_dq_oe,
  output logic                sram_we_n
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  arbState_t        state, stateNxt;
  logic [CNT_W-1:0] waitCnt;
  logic             curPort, grant, latWrite;
  logic [ADDR_W-2:0] latAddr;
  logic [31:0]      latWdata, rdBuf;
  logic             ifDone, memDone, ifPend, memPend, lastBeat, beatHi;

  wire unusedAddrBits = &{1'b0, if_addr[31:ADDR_W+1], if_addr[1:0],
                          mem_addr[31:ADDR_W+1], mem_addr[1:0]};

  assign ifPend    = if_req & ~ifDone;
  assign memPend   = (mem_r_en | mem_w_en) & ~memDone;
  assign freeze    = ifPend | memPend;
  assign if_ready  = ifDone;
  assign mem_ready = memDone;
  assign lastBeat  = (waitCnt == CNT_W'(WAIT_CYCLES - 1));
  assign beatHi    = (state == HI);

  sram_arb_grant uGrant (
    .clk     (clk),
    .rst     (rst),
    .ifPend  (ifPend),
    .memPend (memPend),
    .update  (state == IDLE),
    .grant   (grant)
  );

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (freeze)   stateNxt = LO;
      LO:      if (lastBeat) stateNxt = HI;
      HI:      if (lastBeat) stateNxt = DONE;
      DONE:                  stateNxt = IDLE;
      default:               stateNxt = IDLE;
    endcase
  end

  // Bus is quiet (address 0, no strobe) outside the two beat states, including during reset.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state == LO || state == HI) begin
      sram_addr = {latAddr, beatHi};
      if (latWrite) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        sram_dq_out = beatHi ? latWdata[31:16] : latWdata[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      curPort   <= PORT_IF;
      latAddr   <= '0;
      latWdata  <= '0;
      latWrite  <= 1'b0;
      rdBuf     <= '0;
      ifDone    <= 1'b0;
      memDone   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= stateNxt;
      // Pipeline advances whenever nothing is pending; setting in DONE below overrides this.
      if (!freeze) begin
        ifDone  <= 1'b0;
        memDone <= 1'b0;
      end
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (freeze) begin
            curPort <= grant;
            if (grant == PORT_MEM) begin
              latAddr  <= mem_addr[ADDR_W:2];
              latWdata <= mem_wdata;
              latWrite <= mem_w_en;
            end else begin
              latAddr  <= if_addr[ADDR_W:2];
              latWrite <= 1'b0;
            end
          end
        end
        LO, HI: begin
          if (lastBeat) begin
            waitCnt <= '0;
            if (!latWrite) begin
              if (beatHi) rdBuf[31:16] <= sram_dq_in;
              else        rdBuf[15:0]  <= sram_dq_in;
            end
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        DONE: begin
          if (curPort == PORT_MEM) begin
            memDone <= 1'b1;
            if (!latWrite) mem_rdata <= rdBuf;
          end else begin
            ifDone   <= 1'b1;
            if_rdata <= rdBuf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: pipeline-cycle level model (service order, 4-cycle slots, word memory).
module tb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req, mem_r_en, mem_w_en;
  logic [31:0]       if_addr, mem_addr, mem_wdata;
  logic [31:0]       if_rdata, mem_rdata;
  logic              if_ready, mem_ready, freeze;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out, sram_dq_in;
  logic              sram_dq_oe, sram_we_n;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze(freeze), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  function automatic logic [31:0] initWord(int i);
    if (i == 2) return 32'h1234_5678;
    return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural SRAM: halfword array, written mid-cycle while we_n is low.
  logic [15:0] sram [0:255];
  assign sram_dq_in = sram_dq_oe ? 16'h0000 : sram[sram_addr[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      sram[2*i]   = initWord(i) >> 0;
      sram[2*i+1] = initWord(i) >> 16;
    end
    forever begin
      @(negedge clk);
      if (!sram_we_n) sram[sram_addr[7:0]] = sram_dq_out;
    end
  end

  int          nChecks = 0, nPass = 0;
  logic [31:0] modelMem [0:31];
  logic [31:0] expIfData;
  bit          rrMemFirst;
  int          ifReadyAt, memReadyAt, weLow, freezeCycles;
  int          addrLog [0:15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // One pipeline cycle: requests held until freeze falls, each served access takes a 4-cycle slot.
  task automatic runPipe(input bit ifR, input bit memR, input bit memW,
                         input logic [31:0] ifA, input logic [31:0] memA, input logic [31:0] wd);
    bit memAny, memFirst;
    int n, ifFin, memFin;
    logic [31:0] ifWord, memWord;
    memAny = memR | memW;
    if_req = ifR; mem_r_en = memR; mem_w_en = memW;
    if_addr = ifA; mem_addr = memA; mem_wdata = wd;
    memFirst = 1'b1;
    if (ifR && memAny && RR) begin
      memFirst   = rrMemFirst;
      rrMemFirst = ~rrMemFirst;
    end
    n      = int'(ifR) + int'(memAny);
    ifFin  = (memAny && memFirst) ? 8 : 4;
    memFin = (ifR && !memFirst) ? 8 : 4;
    ifWord = '0; memWord = '0;
    if (memAny && memFirst) begin
      if (memW) modelMem[memA[6:2]] = wd; else memWord = modelMem[memA[6:2]];
    end
    if (ifR) ifWord = modelMem[ifA[6:2]];
    if (memAny && !memFirst) begin
      if (memW) modelMem[memA[6:2]] = wd; else memWord = modelMem[memA[6:2]];
    end
    ifReadyAt = -1; memReadyAt = -1; weLow = 0; freezeCycles = 0;
    for (int k = 0; k <= 4*n; k++) begin
      @(negedge clk);
      if (k < 16) addrLog[k] = int'(sram_addr);
      if (!sram_we_n) weLow++;
      if (freeze) freezeCycles++;
      if (if_ready && ifReadyAt < 0) ifReadyAt = k;
      if (mem_ready && memReadyAt < 0) memReadyAt = k;
      if (ifR && k == ifFin) expIfData = ifWord;
      chk("freeze", 32'(freeze), 32'(k < 4*n));
      chk("if_ready", 32'(if_ready), 32'(ifR && k >= ifFin));
      chk("mem_ready", 32'(mem_ready), 32'(memAny && k >= memFin));
      chk("if_rdata", if_rdata, expIfData);
      if (memR && !memW && k == memFin) chk("mem_rdata", mem_rdata, memWord);
      if (!sram_we_n) chk("dq_oe_on_write", 32'(sram_dq_oe), 32'd1);
      @(posedge clk); #1;
    end
    chk("write_beats", 32'(weLow), memW ? 32'd2 : 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    if_req = 0; mem_r_en = 0; mem_w_en = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0;
    expIfData = 0; rrMemFirst = 1'b1;
    for (int i = 0; i < 32; i++) modelMem[i] = initWord(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_freeze", 32'(freeze), 0);
    chk("rst_we_n", 32'(sram_we_n), 1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 0);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_dq_out", 32'(sram_dq_out), 0);
    chk("rst_ready", {30'd0, if_ready, mem_ready}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    rst = 0;

    // Store interrupted by reset during its low beat.
    @(posedge clk); #1;
    mem_w_en = 1; mem_addr = 32'h10; mem_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("lo_we_n", 32'(sram_we_n), 0);
    chk("lo_addr", 32'(sram_addr), 8);
    chk("lo_dq_out", 32'(sram_dq_out), 32'hBEEF);
    #2 rst = 1; mem_w_en = 0;
    #1;
    chk("midrst_we_n", 32'(sram_we_n), 1);
    chk("midrst_dq_oe", 32'(sram_dq_oe), 0);
    chk("midrst_addr", 32'(sram_addr), 0);
    chk("midrst_freeze", 32'(freeze), 0);
    @(posedge clk); #1 rst = 0;
    chk("postrst_mem_ready", 32'(mem_ready), 0);

    runPipe(1, 0, 0, 32'h0000_0008, 0, 0);
    chk("if_beat0_addr", addrLog[1], 4);
    chk("if_beat1_addr", addrLog[2], 5);
    chk("if_word", if_rdata, 32'h1234_5678);
    chk("if_latency", ifReadyAt, 4);

    runPipe(0, 0, 1, 0, 32'h10, 32'hDEAD_BEEF);
    chk("sram8", 32'(sram[8]), 32'hBEEF);
    chk("sram9", 32'(sram[9]), 32'hDEAD);
    chk("store_latency", memReadyAt, 4);

    runPipe(0, 1, 0, 0, 32'h10, 0);
    chk("readback", mem_rdata, 32'hDEAD_BEEF);

    runPipe(1, 1, 0, 32'h0000_0020, 32'h10, 0);
    chk("both_freeze_cycles", freezeCycles, 8);
    chk("both1_mem_at", memReadyAt, 4);
    chk("both1_if_at", ifReadyAt, 8);

    runPipe(1, 1, 0, 32'h0000_0024, 32'h14, 0);
    chk("both2_mem_at", memReadyAt, RR ? 8 : 4);
    chk("both2_if_at", ifReadyAt, RR ? 4 : 8);

    // Load withdrawn during its high beat still completes once.
    if_req = 0; mem_w_en = 0; mem_r_en = 1; mem_addr = 32'h18;
    w = modelMem[6];
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_r_en = 0;
    @(negedge clk); chk("wd_hi_freeze", 32'(freeze), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("wd_done_ready", 32'(mem_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wd_ready", 32'(mem_ready), 1);
    chk("wd_rdata", mem_rdata, w);
    chk("wd_freeze", 32'(freeze), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("wd_cleared", 32'(mem_ready), 0);
    @(posedge clk); #1;

    for (int t = 0; t < 200; t++) begin
      bit ir, mr, mw;
      int mode;
      ir = bit'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      mr = (mode == 1) || (mode == 2 && $urandom_range(0, 3) == 0);
      mw = (mode == 2);
      runPipe(ir, mr, mw, $urandom & 32'hFFF8_007F, $urandom & 32'hFFF8_007F, $urandom);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
